// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state enum, default widths and round-robin grant helper for div_sched
package div_pkg;

    localparam int M_DEF    = 10;
    localparam int N_DEF    = 4;
    localparam int NREQ_DEF = 3;
    localparam int RR_MAX   = 16;
    localparam int RR_IW    = $clog2(RR_MAX);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // One-hot grant to the first valid requester after ptr, wrapping at nreq.
    function automatic logic [RR_MAX-1:0] rr_grant(
        input logic [RR_MAX-1:0] valid,
        input int                nreq,
        input int                ptr
    );
        logic [RR_MAX-1:0] g;
        logic [RR_IW-1:0]  sel;
        int                idx;
        logic              found;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            idx = ptr + i;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            sel = RR_IW'(idx);
            if (i <= nreq && !found && valid[sel]) begin
                g[sel] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/div_seq_core.sv
// rtl/div_seq_core.sv - iterative restoring divider, one quotient bit per clock, MSB first
module div_seq_core
    import div_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [M:0] did,
    input  logic [N:0] div,
    output logic       done,
    output logic [M:0] quo,
    output logic [M:0] rem,
    output logic       error
);

    localparam int CW = $clog2(M + 1);

    logic [M:0]    did_r;
    logic [N:0]    div_r;
    logic [N:0]    pr;
    logic [M:0]    q;
    logic [CW-1:0] cnt;
    logic          run;
    logic          zero_r;

    logic [N+1:0]  shifted;
    logic [N+1:0]  pr_next;
    logic          ge;
    logic [M:0]    q_next;

    // pr < div before each shift, so the shifted value always fits N+2 bits.
    always_comb begin
        shifted = {pr, did_r[cnt]};
        ge      = shifted >= {1'b0, div_r};
        pr_next = ge ? shifted - {1'b0, div_r} : shifted;
        q_next  = {q[M-1:0], ge};
    end

    assign done = run && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            did_r  <= '0;
            div_r  <= '0;
            pr     <= '0;
            q      <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            zero_r <= 1'b0;
            quo    <= '0;
            rem    <= '0;
            error  <= 1'b0;
        end else if (start) begin
            did_r  <= did;
            div_r  <= div;
            pr     <= '0;
            q      <= '0;
            run    <= 1'b1;
            zero_r <= (div == '0);
            // a zero divisor spends a single cycle here and reports the error
            cnt    <= (div == '0) ? '0 : CW'(M);
        end else if (run) begin
            pr  <= pr_next[N:0];
            q   <= q_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                run   <= 1'b0;
                quo   <= zero_r ? '0 : q_next;
                rem   <= zero_r ? '0 : (M+1)'(pr_next);
                error <= zero_r;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - round-robin scheduler in front of one shared sequential divider
module div_sched
    import div_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int M    = M_DEF,
    parameter int N    = N_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*(M+1)-1:0] req_did,
    input  logic [NREQ*(N+1)-1:0] req_div,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [M:0]            rsp_quo,
    output logic [M:0]            rsp_rem,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    state_t            state_n;
    logic [PW-1:0]     ptr;
    logic [NREQ-1:0]   owner;
    logic [RR_MAX-1:0] grant_all;
    logic [PW-1:0]     gidx;
    logic              accept;
    logic              core_done;
    logic [M:0]        did_sel;
    logic [N:0]        div_sel;

    always_comb begin
        grant_all = rr_grant(RR_MAX'(req_valid), NREQ, int'(ptr));
        gidx      = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            if (grant_all[i]) begin
                gidx = PW'(i);
            end
        end
        req_ready = (state == IDLE && !rst) ? grant_all[NREQ-1:0] : '0;
        accept    = |req_ready;
    end

    assign did_sel = req_did[gidx*(M+1) +: (M+1)];
    assign div_sel = req_div[gidx*(N+1) +: (N+1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= PW'(NREQ - 1);
            owner <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                ptr   <= gidx;
                owner <= req_ready;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = CALC;
            CALC:    if (core_done) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rsp_valid = (state == DONE) ? owner : '0;
    assign busy      = (state != IDLE);

    div_seq_core #(
        .M(M),
        .N(N)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .start(accept),
        .did  (did_sel),
        .div  (div_sel),
        .done (core_done),
        .quo  (rsp_quo),
        .rem  (rsp_rem),
        .error(rsp_error)
    );

endmodule
